// File: rtl/lvp_pkg.sv
// ============================================================================
// Module   : lvp_pkg
// Purpose  : Shared types and constants for the load-value speculation unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lvp_pkg;

  localparam int c_data_width = 32;
  localparam int c_pc_width   = 32;
  localparam int c_conf_width = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPEC    = 2'd1,
    RECOVER = 2'd2
  } lvp_state_e;

  typedef struct packed {
    logic                    valid;
    logic [c_pc_width-1:0]   tag;
    logic [c_data_width-1:0] data;
    logic [c_conf_width-1:0] conf;
  } lvp_tbl_entry_t;

  typedef struct packed {
    logic [c_pc_width-1:0]   pc;
    logic                    predicted;
    logic [c_data_width-1:0] pred_data;
  } lvp_q_entry_t;

  function automatic logic [c_conf_width-1:0] conf_sat_inc(
    input logic [c_conf_width-1:0] conf,
    input int unsigned             conf_max
  );
    if (conf >= c_conf_width'(conf_max)) return conf;
    return conf + c_conf_width'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lvp_table.sv
// ============================================================================
// Module   : lvp_table
// Purpose  : Direct-mapped last-value table, combinational read, train-on-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lvp_table
  import lvp_pkg::*;
#(
  parameter int ENTRIES   = 64,
  parameter int CONF_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx,
  output lvp_tbl_entry_t             rd_entry,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [c_pc_width-1:0]      wr_tag,
  input  logic [c_data_width-1:0]    wr_data
);

  localparam int unsigned c_conf_max = (1 << CONF_BITS) - 1;

  lvp_tbl_entry_t r_tbl [ENTRIES];
  lvp_tbl_entry_t w_cur;
  lvp_tbl_entry_t w_new;

  // Reads see the pre-update contents on a same-cycle write.
  assign rd_entry = r_tbl[rd_idx];
  assign w_cur    = r_tbl[wr_idx];

  always_comb begin
    w_new.valid = 1'b1;
    w_new.tag   = wr_tag;
    w_new.data  = wr_data;
    w_new.conf  = '0;
    if (w_cur.valid && (w_cur.tag == wr_tag) && (w_cur.data == wr_data)) begin
      w_new.conf = conf_sat_inc(w_cur.conf, c_conf_max);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (wr_en) begin
      r_tbl[wr_idx] <= w_new;
    end
  end

endmodule

`default_nettype wire

// File: rtl/load_value_spec_unit.sv
// ============================================================================
// Module   : load_value_spec_unit
// Purpose  : Predicts D-cache miss data, tracks outstanding misses in order,
//            verifies against fills and requests snapshot/recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_value_spec_unit
  import lvp_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int PC_WIDTH    = 32,
  parameter int ENTRIES     = 64,
  parameter int CONF_BITS   = 2,
  parameter int CONF_THRESH = 2,
  parameter int MAX_OUT     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [PC_WIDTH-1:0]   miss_pc,
  output logic                  miss_ready,
  output logic                  pred_valid,
  output logic [DATA_WIDTH-1:0] pred_data,
  output logic                  snapshot_req,
  input  logic                  fill_valid,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  recover,
  output logic [PC_WIDTH-1:0]   recover_pc,
  input  logic                  recovery_done,
  output logic                  spec_active
);

  localparam int c_idx_w = $clog2(ENTRIES);
  localparam int c_qa_w  = $clog2(MAX_OUT);
  localparam int c_ptr_w = c_qa_w + 1;
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  lvp_state_e          r_state;
  lvp_state_e          w_state_nxt;
  lvp_q_entry_t        r_q [MAX_OUT];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_pred_cnt;
  logic [c_ptr_w-1:0]  w_pred_cnt_nxt;
  logic                r_recover;
  logic [PC_WIDTH-1:0] r_recover_pc;

  lvp_tbl_entry_t          w_rd;
  lvp_q_entry_t            w_head;
  logic [c_pc_width-1:0]   w_miss_tag;
  logic [c_pc_width-1:0]   w_head_tag;
  logic [c_data_width-1:0] w_fill_data;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_hit;
  logic                    w_deq;
  logic                    w_bad;
  logic                    w_good;

  assign w_miss_tag  = c_pc_width'(miss_pc >> (c_idx_w + 2));
  assign w_head      = r_q[r_rd_ptr[c_qa_w-1:0]];
  assign w_head_tag  = w_head.pc >> (c_idx_w + 2);
  assign w_fill_data = c_data_width'(fill_data);

  lvp_table #(
    .ENTRIES  (ENTRIES),
    .CONF_BITS(CONF_BITS)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (miss_pc[c_idx_w+1:2]),
    .rd_entry(w_rd),
    .wr_en   (w_deq),
    .wr_idx  (w_head.pc[c_idx_w+1:2]),
    .wr_tag  (w_head_tag),
    .wr_data (w_fill_data)
  );

  assign w_full  = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                   (r_wr_ptr[c_qa_w-1:0] == r_rd_ptr[c_qa_w-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign miss_ready   = (r_state != RECOVER) && !w_full;
  assign w_accept     = miss_valid && miss_ready;
  assign w_hit        = w_rd.valid && (w_rd.tag == w_miss_tag);
  assign pred_valid   = w_accept && w_hit && (w_rd.conf >= c_conf_width'(CONF_THRESH));
  assign pred_data    = pred_valid ? DATA_WIDTH'(w_rd.data) : '0;
  assign snapshot_req = pred_valid && (r_state == IDLE);

  // Fills arriving with nothing outstanding or during recovery are dropped.
  assign w_deq  = fill_valid && !w_empty && (r_state != RECOVER);
  assign w_bad  = w_deq && w_head.predicted && (w_fill_data != w_head.pred_data)
                  && (r_state == SPEC);
  assign w_good = w_deq && w_head.predicted && (w_fill_data == w_head.pred_data);

  always_comb begin
    w_pred_cnt_nxt = r_pred_cnt;
    if (pred_valid) w_pred_cnt_nxt = w_pred_cnt_nxt + c_ptr_one;
    if (w_deq && w_head.predicted) w_pred_cnt_nxt = w_pred_cnt_nxt - c_ptr_one;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (pred_valid) w_state_nxt = SPEC;
      SPEC: begin
        if (w_bad) w_state_nxt = RECOVER;
        else if (w_pred_cnt_nxt == '0) w_state_nxt = IDLE;
      end
      RECOVER: if (recovery_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A mispredict discards every queued miss, including one accepted this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pred_cnt   <= '0;
      r_recover    <= 1'b0;
      r_recover_pc <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_recover <= w_bad;
      if (w_bad) begin
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_pred_cnt   <= '0;
        r_recover_pc <= PC_WIDTH'(w_head.pc);
      end else begin
        if (w_accept) begin
          r_q[r_wr_ptr[c_qa_w-1:0]].pc        <= c_pc_width'(miss_pc);
          r_q[r_wr_ptr[c_qa_w-1:0]].predicted <= pred_valid;
          r_q[r_wr_ptr[c_qa_w-1:0]].pred_data <= pred_valid ? w_rd.data : '0;
          r_wr_ptr <= r_wr_ptr + c_ptr_one;
        end
        if (w_deq) r_rd_ptr <= r_rd_ptr + c_ptr_one;
        r_pred_cnt <= w_pred_cnt_nxt;
      end
    end
  end

  assign recover     = r_recover;
  assign recover_pc  = r_recover_pc;
  assign spec_active = (r_pred_cnt != '0);

`ifndef SYNTHESIS
  // Event counters for simulation statistics: vp_issued, vp_correct, vp_recover.
  logic [31:0] r_stat_vp_issued;
  logic [31:0] r_stat_vp_correct;
  logic [31:0] r_stat_vp_recover;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_vp_issued  <= '0;
      r_stat_vp_correct <= '0;
      r_stat_vp_recover <= '0;
    end else begin
      if (pred_valid) r_stat_vp_issued  <= r_stat_vp_issued + 32'd1;
      if (w_good)     r_stat_vp_correct <= r_stat_vp_correct + 32'd1;
      if (w_bad)      r_stat_vp_recover <= r_stat_vp_recover + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
